// File: rtl/rally_referee.sv
// Rally rule engine: credits touches to sides, detects over-touch and ground faults, keeps score.
// All outputs registered, one clk after the qualifying collision edge; no backpressure (edges outside a live rally are dropped).
module rally_referee #(
  parameter int MAX_TOUCHES  = 3,
  parameter int WIN_SCORE    = 15,
  parameter int NET_POSX     = 512,
  parameter int BALL_SIZE    = 64,
  parameter int GUARD_CYCLES = 16_250_000,
  parameter int HOLD_CYCLES  = 162_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic        gnd_col,
  input  logic [11:0] ball_posx,
  input  logic        new_game,
  output logic        last_touch,
  output logic        ovr_touch,
  output logic [2:0]  touch_cnt,
  output logic [4:0]  pl1_score,
  output logic [4:0]  pl2_score,
  output logic        point_pl1,
  output logic        point_pl2,
  output logic        game_over
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_HOLD, S_OVER} state_t;

  state_t        r_state;
  logic          r_pl1_d, r_pl2_d, r_gnd_d;
  logic [GW-1:0] r_guard;
  logic [HW-1:0] r_hold;
  logic          r_last, r_ovr, r_pt1, r_pt2, r_over;
  logic [2:0]    r_cnt;
  logic [4:0]    r_s1, r_s2;

  logic        w_pl1_rise, w_pl2_rise, w_gnd_rise;
  logic [12:0] w_center;
  logic        w_side;
  logic        w_in_rally;
  logic        w_touch_ok;
  logic        w_toucher;
  logic [2:0]  w_cnt_next;
  logic        w_fault;
  logic        w_gnd_pt;
  logic        w_award;
  logic        w_winner;
  logic [4:0]  w_win_score;

  assign w_pl1_rise = pl1_col & ~r_pl1_d;
  assign w_pl2_rise = pl2_col & ~r_pl2_d;
  assign w_gnd_rise = gnd_col & ~r_gnd_d;

  // Side is decided from the ball centre; 13 bits so the centre never wraps.
  assign w_center = {1'b0, ball_posx} + 13'(BALL_SIZE / 2);
  assign w_side   = (w_center >= 13'(NET_POSX));

  assign w_in_rally = (r_state == S_SERVE) || (r_state == S_PLAY);
  assign w_gnd_pt   = (r_state == S_PLAY) && w_gnd_rise;
  assign w_touch_ok = w_in_rally && (w_pl1_rise || w_pl2_rise) &&
                      (r_guard == '0) && !w_gnd_pt;
  assign w_toucher  = (w_pl1_rise && w_pl2_rise) ? w_side : w_pl2_rise;

  always_comb begin
    w_cnt_next = 3'd1;
    if ((w_toucher == r_last) && (r_cnt != 3'd0))
      w_cnt_next = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
  end

  assign w_fault     = (r_state == S_PLAY) && (w_cnt_next == 3'(MAX_TOUCHES + 1));
  assign w_award     = w_gnd_pt || (w_touch_ok && w_fault);
  assign w_winner    = w_gnd_pt ? ~w_side : ~w_toucher;
  assign w_win_score = w_winner ? r_s2 + 5'd1 : r_s1 + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_SERVE;
      r_pl1_d <= 1'b0;
      r_pl2_d <= 1'b0;
      r_gnd_d <= 1'b0;
      r_guard <= '0;
      r_hold  <= '0;
      r_last  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= 3'd0;
      r_s1    <= 5'd0;
      r_s2    <= 5'd0;
      r_pt1   <= 1'b0;
      r_pt2   <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_pl1_d <= pl1_col;
      r_pl2_d <= pl2_col;
      r_gnd_d <= gnd_col;
      r_pt1   <= 1'b0;
      r_pt2   <= 1'b0;
      if (r_guard != '0)
        r_guard <= r_guard - GW'(1);

      case (r_state)
        S_SERVE, S_PLAY: begin
          if (w_touch_ok) begin
            r_guard <= GW'(GUARD_CYCLES);
            r_cnt   <= w_cnt_next;
            r_last  <= w_toucher;
            r_state <= S_PLAY;
            if (w_fault)
              r_ovr <= 1'b1;
          end
          // Later assignments override the touch bookkeeping: the winner serves.
          if (w_award) begin
            if (w_winner) begin
              r_s2  <= w_win_score;
              r_pt2 <= 1'b1;
            end else begin
              r_s1  <= w_win_score;
              r_pt1 <= 1'b1;
            end
            r_last <= w_winner;
            if (w_win_score == 5'(WIN_SCORE)) begin
              r_state <= S_OVER;
              r_over  <= 1'b1;
            end else begin
              r_state <= S_HOLD;
              r_hold  <= HW'(HOLD_CYCLES);
            end
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            r_cnt   <= 3'd0;
            r_ovr   <= 1'b0;
            r_guard <= '0;
            r_state <= S_SERVE;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        S_OVER: begin
          if (new_game) begin
            r_s1    <= 5'd0;
            r_s2    <= 5'd0;
            r_cnt   <= 3'd0;
            r_last  <= 1'b0;
            r_ovr   <= 1'b0;
            r_over  <= 1'b0;
            r_state <= S_SERVE;
          end
        end
        default: r_state <= S_SERVE;
      endcase
    end
  end

  assign last_touch = r_last;
  assign ovr_touch  = r_ovr;
  assign touch_cnt  = r_cnt;
  assign pl1_score  = r_s1;
  assign pl2_score  = r_s2;
  assign point_pl1  = r_pt1;
  assign point_pl2  = r_pt2;
  assign game_over  = r_over;

endmodule

// File: tb/tb_rally_referee.sv
// Bench for rally_referee: directed rally scenarios plus random collisions against a timeline-based rule model.
module tb_rally_referee;

  localparam int GUARD = 8;
  localparam int HOLD  = 16;
  localparam int MAXT  = 3;
  localparam int WIN   = 15;

  logic        clk;
  logic        rst;
  logic        pl1_col, pl2_col, gnd_col, new_game;
  logic [11:0] ball_posx;
  logic        last_touch, ovr_touch, point_pl1, point_pl2, game_over;
  logic [2:0]  touch_cnt;
  logic [4:0]  pl1_score, pl2_score;

  int vectors;
  int miscompares;

  rally_referee #(
    .MAX_TOUCHES(MAXT), .WIN_SCORE(WIN), .NET_POSX(512), .BALL_SIZE(64),
    .GUARD_CYCLES(GUARD), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .pl1_col(pl1_col), .pl2_col(pl2_col), .gnd_col(gnd_col),
    .ball_posx(ball_posx), .new_game(new_game), .last_touch(last_touch),
    .ovr_touch(ovr_touch), .touch_cnt(touch_cnt), .pl1_score(pl1_score),
    .pl2_score(pl2_score), .point_pl1(point_pl1), .point_pl2(point_pl2),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule model: phases plus absolute-time deadlines for guard and hold.
  localparam int PH_SERVE = 0, PH_PLAY = 1, PH_HOLD = 2, PH_OVER = 3;
  int     m_phase;
  longint m_cyc, m_guard_free, m_hold_end;
  bit     m_prev1, m_prev2, m_prevg;
  bit     m_last, m_ovr, m_p1, m_p2, m_over;
  int     m_cnt, m_s1, m_s2;

  task award(input bit w);
    int sc;
    if (w) begin m_s2 = m_s2 + 1; m_p2 = 1; sc = m_s2; end
    else   begin m_s1 = m_s1 + 1; m_p1 = 1; sc = m_s1; end
    m_last = w;
    if (sc == WIN) begin m_phase = PH_OVER; m_over = 1; end
    else begin m_phase = PH_HOLD; m_hold_end = m_cyc + HOLD + 1; end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_SERVE; m_cyc = 0; m_guard_free = 0; m_hold_end = 0;
      m_prev1 = 0; m_prev2 = 0; m_prevg = 0;
      m_last = 0; m_ovr = 0; m_p1 = 0; m_p2 = 0; m_over = 0;
      m_cnt = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      bit r1, r2, rg, side, p;
      r1 = pl1_col && !m_prev1;
      r2 = pl2_col && !m_prev2;
      rg = gnd_col && !m_prevg;
      side = (int'(ball_posx) + 32) >= 512;
      m_p1 = 0; m_p2 = 0;
      if (m_phase == PH_PLAY && rg) begin
        award(!side);
      end else if ((m_phase == PH_SERVE || m_phase == PH_PLAY) && (r1 || r2) && m_cyc >= m_guard_free) begin
        p = (r1 && r2) ? side : r2;
        if (p == m_last && m_cnt > 0) m_cnt = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
        else begin m_cnt = 1; m_last = p; end
        m_guard_free = m_cyc + GUARD + 1;
        if (m_phase == PH_PLAY && m_cnt == MAXT + 1) begin
          m_ovr = 1;
          award(!p);
        end else begin
          m_phase = PH_PLAY;
        end
      end else if (m_phase == PH_HOLD && m_cyc >= m_hold_end) begin
        m_cnt = 0; m_ovr = 0; m_guard_free = 0; m_phase = PH_SERVE;
      end else if (m_phase == PH_OVER && new_game) begin
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_last = 0; m_ovr = 0; m_over = 0;
        m_phase = PH_SERVE;
      end
      m_prev1 = pl1_col; m_prev2 = pl2_col; m_prevg = gnd_col;
      m_cyc = m_cyc + 1;
    end
  end

  // Per-cycle compare on the falling edge, when registered outputs are stable.
  always @(negedge clk) begin
    logic [17:0] got, exp;
    got = {last_touch, ovr_touch, touch_cnt, pl1_score, pl2_score, point_pl1, point_pl2, game_over};
    exp = {m_last, m_ovr, 3'(m_cnt), 5'(m_s1), 5'(m_s2), m_p1, m_p2, m_over};
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      if (miscompares < 25)
        $display("FAIL cycle_model t=%0t got={lt,ov,cnt,s1,s2,p1,p2,go}=%h required=%h", $time, got, exp);
    end
  end

  task automatic lit(input string name, input int actual, input int expected);
    vectors = vectors + 1;
    if (actual != expected) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit a, input bit b, input bit g, input logic [11:0] x);
    pl1_col = a; pl2_col = b; gnd_col = g; ball_posx = x;
    step();
  endtask

  task automatic idle(input int n);
    pl1_col = 0; pl2_col = 0; gnd_col = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0; step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1; pl1_col = 0; pl2_col = 0; gnd_col = 0; new_game = 0; ball_posx = 12'd0;
    repeat (3) step();
    rst = 0; step();
    lit("reset_last", int'(last_touch), 0);
    lit("reset_cnt", int'(touch_cnt), 0);
    lit("reset_scores", int'({pl1_score, pl2_score}), 0);
    lit("reset_flags", int'({ovr_touch, point_pl1, point_pl2, game_over}), 0);

    // Long pl1 contact counts once.
    drive(1, 0, 0, 200);
    lit("hold20_cnt_first", int'(touch_cnt), 1);
    lit("hold20_last", int'(last_touch), 0);
    repeat (19) drive(1, 0, 0, 200);
    lit("hold20_cnt_end", int'(touch_cnt), 1);
    idle(2);
    do_reset();
    lit("midrally_reset_cnt", int'(touch_cnt), 0);

    // Second rise inside guard window is dropped.
    drive(1, 0, 0, 200); drive(1, 0, 0, 200); drive(0, 0, 0, 200); drive(0, 0, 0, 200);
    drive(1, 0, 0, 200);
    lit("guard_drop_cnt", int'(touch_cnt), 1);
    idle(12);
    do_reset();

    // Four pl1 touches: over-touch fault.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 200);
      if (i < 3) begin
        lit("multi_touch_cnt", int'(touch_cnt), i + 1);
        idle(9);
      end
    end
    lit("fault_ovr", int'(ovr_touch), 1);
    lit("fault_point_pl2", int'(point_pl2), 1);
    lit("fault_pl2_score", int'(pl2_score), 1);
    lit("fault_last", int'(last_touch), 1);
    idle(20);
    lit("hold_end_ovr", int'(ovr_touch), 0);
    lit("hold_end_cnt", int'(touch_cnt), 0);

    // Ground ignored in SERVE, then a two-side rally ending on pl1 ground.
    drive(0, 0, 1, 200); idle(1);
    lit("serve_gnd_ignored", int'({pl1_score, pl2_score}), 1);
    drive(1, 0, 0, 200); idle(9);
    drive(0, 1, 0, 200);
    lit("pl2_touch_cnt", int'(touch_cnt), 1);
    lit("pl2_touch_last", int'(last_touch), 1);
    idle(9);
    drive(0, 0, 1, 200);
    lit("gnd_pl2_score", int'(pl2_score), 2);
    lit("gnd_last", int'(last_touch), 1);
    idle(20);

    // Give pl1 a point so last_touch is PLAYER1 before the simultaneous test.
    drive(1, 0, 0, 200); idle(2);
    drive(0, 0, 1, 700);
    lit("pl1_point_score", int'(pl1_score), 1);
    idle(20);
    drive(1, 1, 0, 600);
    lit("simul_credit_last", int'(last_touch), 1);
    lit("simul_cnt", int'(touch_cnt), 1);
    idle(9);
    drive(0, 1, 1, 600);
    lit("gnd_wins_pl1_score", int'(pl1_score), 2);
    lit("gnd_wins_cnt", int'(touch_cnt), 1);
    lit("gnd_wins_point_pl1", int'(point_pl1), 1);
    idle(20);

    // Play pl1 up to the winning score.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, 200); idle(2);
      drive(0, 0, 1, 700); idle(20);
    end
    lit("pl1_at_14", int'(pl1_score), 14);
    drive(1, 0, 0, 200); idle(2);
    drive(0, 0, 1, 700);
    lit("win_score", int'(pl1_score), 15);
    lit("win_game_over", int'(game_over), 1);
    idle(2);
    drive(1, 0, 0, 200); idle(2);
    drive(0, 0, 1, 200); idle(2);
    lit("over_ignores_edges", int'({pl1_score, pl2_score}), 15 * 32);
    new_game = 1; step(); new_game = 0;
    lit("new_game_score", int'(pl1_score), 0);
    lit("new_game_over", int'(game_over), 0);
    drive(0, 1, 0, 600);
    lit("new_game_serve", int'(touch_cnt), 1);
    idle(20);

    // Random collisions, positions, new_game and occasional resets.
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(0, 11) == 0) pl1_col = ~pl1_col;
      if ($urandom_range(0, 11) == 0) pl2_col = ~pl2_col;
      if ($urandom_range(0, 15) == 0) gnd_col = ~gnd_col;
      if ($urandom_range(0, 3) == 0)
        ball_posx = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(400, 560));
      new_game = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 0; new_game = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
